// File: rtl/pio_in_capture_pkg.sv
// pio_in_capture_pkg: register offsets and edge-select encodings for the PIO
package pio_in_capture_pkg;
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_type_e;
endpackage

// File: rtl/pio_in_capture_sync_edge.sv
// pio_in_capture_sync_edge: per-bit input synchroniser and compile-time selected edge detector
module pio_in_capture_sync_edge
    import pio_in_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] det
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] prev;
    // prev resets alongside the chain, so the first cycle after reset sees no edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in_port};
            prev  <= sync;
        end
    end
    assign sync = chain[SYNC_STAGES-1];
    assign det = EDGE_TYPE == int'(EDGE_FALL) ? ~sync & prev :
                 EDGE_TYPE == int'(EDGE_ANY)  ? sync ^ prev  : sync & ~prev;
endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM PIO with synchronised inputs, edge capture, masked IRQ and set/clear outputs
module pio_in_capture
    import pio_in_capture_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    logic [WIDTH-1:0] sync, det, irq_mask, edge_cap, out_reg, wd, clr, out_next, rd_mux;
    logic wr, unused_writedata;
    pio_in_capture_sync_edge #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)
    ) u_sync_edge (
        .clk(clk), .reset(reset), .in_port(in_port), .sync(sync), .det(det)
    );
    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;
    always_comb begin
        clr = (wr && address == ADDR_EDGECAP) ? wd : '0;
        out_next = !wr                     ? out_reg :
                   address == ADDR_DATA    ? wd :
                   address == ADDR_OUTSET  ? out_reg | wd :
                   address == ADDR_OUTCLR  ? out_reg & ~wd : out_reg;
        rd_mux = address == ADDR_DATA    ? sync :
                 address == ADDR_IRQMASK ? irq_mask :
                 address == ADDR_EDGECAP ? edge_cap :
                 (address == ADDR_OUTSET || address == ADDR_OUTCLR) ? out_reg : '0;
    end
    // detect is OR'd after the clear so a same-cycle W1C never loses a new edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            out_reg  <= OUT_RESET;
            readdata <= '0;
        end else begin
            if (wr && address == ADDR_IRQMASK) irq_mask <= wd;
            edge_cap <= (edge_cap & ~clr) | det;
            out_reg  <= out_next;
            readdata <= 32'(rd_mux);
        end
    end
    assign out_port = out_reg;
    assign irq = |(edge_cap & irq_mask);
endmodule
